// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared command encodings, FSM states and bit timing constants for the I2C master
package i2c_pkg;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_STOP  = 2'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_BIT   = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int unsigned TICKS_PER_BIT = 4;
    localparam int unsigned NUM_BITS      = 9;

    localparam logic [1:0] LAST_PHASE = 2'(TICKS_PER_BIT - 1);
    localparam logic [3:0] LAST_BIT   = 4'(NUM_BITS - 1);

    // SDA pull-down for data bit idx of a byte transfer (idx 8 is the acknowledge slot)
    function automatic logic bit_sda_oe(input logic [1:0] op, input logic [7:0] data,
                                        input logic ack, input logic [3:0] idx);
        logic [3:0] sel;
        sel = 4'd7 - idx;
        if (idx == LAST_BIT) begin
            return (op == OP_READ) ? ack : 1'b0;
        end
        return (op == OP_WRITE) ? ~data[sel[2:0]] : 1'b0;
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// rtl/i2c_tick_gen.sv - quarter-bit tick generator, one pulse every CLK_DIV cycles
module i2c_tick_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = ~clr & (cnt == LAST);

    // free-running divider, restarted while the controller is idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - command-driven I2C master: START, byte WRITE, byte READ, STOP
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] wr_data,
    input  logic       rd_ack,
    output logic [7:0] rd_data,
    output logic       ack_rx,
    output logic       done,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);

    logic [2:0] state;
    logic [1:0] op_q;
    logic [7:0] wr_q;
    logic       rd_ack_q;
    logic [1:0] phase;
    logic [3:0] bit_cnt;
    logic       bus_held;
    logic       tick;
    logic       accept;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid & cmd_ready;

    i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cmd_ready),
        .tick  (tick)
    );

    // single controller FSM: command latch, line sequencing and sampling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            op_q     <= OP_START;
            wr_q     <= 8'h00;
            rd_ack_q <= 1'b0;
            phase    <= 2'd0;
            bit_cnt  <= 4'd0;
            bus_held <= 1'b0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            done     <= 1'b0;
            rd_data  <= 8'h00;
            ack_rx   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q     <= cmd_op;
                        wr_q     <= wr_data;
                        rd_ack_q <= rd_ack;
                        phase    <= 2'd0;
                        bit_cnt  <= 4'd0;
                        case (cmd_op)
                            OP_START: begin
                                state  <= ST_START;
                                scl_oe <= 1'b0;
                                sda_oe <= 1'b0;
                            end
                            OP_STOP: begin
                                state  <= ST_STOP;
                                scl_oe <= 1'b1;
                                sda_oe <= 1'b1;
                            end
                            default: begin
                                // phase 0 of bit 0: SCL low, first data bit presented
                                state  <= ST_BIT;
                                scl_oe <= 1'b1;
                                sda_oe <= bit_sda_oe(cmd_op, wr_data, rd_ack, 4'd0);
                            end
                        endcase
                    end
                end
                ST_START: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        if (phase == 2'd1) begin
                            sda_oe <= 1'b1;
                        end
                        if (phase == LAST_PHASE) begin
                            // SCL parked low, SDA handed back for the first data bit
                            scl_oe   <= 1'b1;
                            sda_oe   <= 1'b0;
                            bus_held <= 1'b1;
                            done     <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        if (phase == 2'd1) begin
                            scl_oe <= 1'b0;
                        end
                        if (phase == LAST_PHASE) begin
                            sda_oe   <= 1'b0;
                            bus_held <= 1'b0;
                            done     <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_BIT: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        case (phase)
                            2'd1: scl_oe <= 1'b0;
                            2'd2: begin
                                // sample point: SCL has been high for one full tick
                                if (bit_cnt == LAST_BIT) begin
                                    if (op_q == OP_WRITE) begin
                                        ack_rx <= ~sda_i;
                                    end
                                end else if (op_q == OP_READ) begin
                                    rd_data <= {rd_data[6:0], sda_i};
                                end
                            end
                            2'd3: begin
                                scl_oe <= 1'b1;
                                if (bit_cnt == LAST_BIT) begin
                                    sda_oe   <= 1'b0;
                                    bus_held <= 1'b1;
                                    done     <= 1'b1;
                                    state    <= ST_DONE;
                                end else begin
                                    bit_cnt <= bit_cnt + 4'd1;
                                    sda_oe  <= bit_sda_oe(op_q, wr_q, rd_ack_q, bit_cnt + 4'd1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    scl_oe <= bus_held;
                    sda_oe <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb/tb_i2c_master_ctrl.sv - directed scoreboard bench for i2c_master_ctrl with an open-drain slave model
module tb_i2c_master_ctrl;
    import i2c_pkg::*;

    localparam int CLK_DIV = 4;

    localparam int SEL_LAT  = 0;
    localparam int SEL_RD   = 1;
    localparam int SEL_ACK  = 2;
    localparam int SEL_SCL  = 3;
    localparam int SEL_SDA  = 4;
    localparam int SEL_CAP  = 5;
    localparam int SEL_MCAP = 6;
    localparam int SEL_FALL = 7;
    localparam int SEL_GAP  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_ack = 1'b0;
    logic [7:0] rd_data;
    logic       ack_rx;
    logic       done;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_i;
    logic       s_oe = 1'b0;

    assign sda_i = ~(sda_oe | s_oe);

    i2c_master_ctrl #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .wr_data   (wr_data),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data),
        .ack_rx    (ack_rx),
        .done      (done),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .sda_i     (sda_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // slave model and bus monitor
    int         smode = 0;
    logic [7:0] sbyte = 8'h00;
    int         rises = 0;
    logic [8:0] cap = 9'h0;
    logic [8:0] mcap = 9'h0;
    int         fall_cyc = -1;
    logic       prev_scl = 1'b0;
    logic       prev_sda = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            s_oe = 1'b0;
        end else if (cmd_valid && cmd_ready) begin
            rises    = 0;
            cap      = 9'h0;
            mcap     = 9'h0;
            fall_cyc = -1;
            s_oe     = (smode == 2) ? ~sbyte[7] : 1'b0;
        end else begin
            if (scl_oe && !prev_scl) begin
                if (smode == 1) s_oe = (rises == 8);
                else if (smode == 2) s_oe = (rises < 8) ? ~sbyte[3'(7 - rises)] : 1'b0;
                else s_oe = 1'b0;
            end
            if (!scl_oe && prev_scl) begin
                rises = rises + 1;
                cap   = {cap[7:0], sda_i};
                mcap  = {mcap[7:0], sda_oe};
            end
            if (sda_oe && !prev_sda && !scl_oe) fall_cyc = cyc;
        end
        prev_scl = scl_oe;
        prev_sda = sda_oe;
    end

    typedef struct {
        string tag;
        int    sel;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   vecs = 0;
    int   fails = 0;
    int   acc = 0;
    int   last_lat = 0;
    int   last_done = 0;
    int   gap = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_LAT:  return last_lat;
            SEL_RD:   return {24'd0, rd_data};
            SEL_ACK:  return {31'd0, ack_rx};
            SEL_SCL:  return {31'd0, scl_oe};
            SEL_SDA:  return {31'd0, sda_oe};
            SEL_CAP:  return {23'd0, cap};
            SEL_MCAP: return {23'd0, mcap};
            SEL_FALL: return (fall_cyc < 0) ? -1 : fall_cyc - acc;
            default:  return gap;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input int exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, input logic ra, input bit keep);
        int   n;
        bit   ok;
        exp_t e;
        cmd_op    = op;
        wr_data   = d;
        rd_ack    = ra;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 400) begin
            @(posedge clk); #2;
            n++;
        end
        acc = cyc + 1;
        gap = acc - last_done;
        @(posedge clk); #2;
        if (!keep) cmd_valid = 1'b0;
        cmd_op  = ~op;
        wr_data = ~d;
        rd_ack  = ~ra;
        ok = 1'b0;
        n  = 0;
        while (n < 2000) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #2;
            n++;
        end
        last_lat  = ok ? cyc - acc + 1 : -1;
        last_done = cyc;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    initial begin
        int n;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_scl_oe", {31'd0, scl_oe}, 0);
        check("rst_sda_oe", {31'd0, sda_oe}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_rd_data", {24'd0, rd_data}, 0);
        check("rst_ack_rx", {31'd0, ack_rx}, 0);
        rst_n = 1'b1;
        #1;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
        @(posedge clk); #2;

        // START then STOP
        smode = 0;
        expect_val("start_latency", SEL_LAT, 4 * CLK_DIV + 1);
        expect_val("start_sda_fall", SEL_FALL, 2 * CLK_DIV);
        expect_val("start_scl_held", SEL_SCL, 1);
        expect_val("start_sda_rel", SEL_SDA, 0);
        run_cmd(OP_START, 8'h00, 1'b0, 1'b0);
        expect_val("stop_latency", SEL_LAT, 4 * CLK_DIV + 1);
        expect_val("stop_scl_rel", SEL_SCL, 0);
        expect_val("stop_sda_rel", SEL_SDA, 0);
        run_cmd(OP_STOP, 8'h00, 1'b0, 1'b0);

        // START, WRITE 0xA5 with slave ACK
        expect_val("start2_latency", SEL_LAT, 4 * CLK_DIV + 1);
        run_cmd(OP_START, 8'h00, 1'b0, 1'b0);
        smode = 1;
        expect_val("wr_a5_latency", SEL_LAT, 36 * CLK_DIV + 1);
        expect_val("wr_a5_bits", SEL_CAP, 9'h14A);
        expect_val("wr_a5_ack", SEL_ACK, 1);
        run_cmd(OP_WRITE, 8'hA5, 1'b0, 1'b0);

        // READ 0x5E with NACK, then READ 0xC3 with ACK
        smode = 2;
        sbyte = 8'h5E;
        expect_val("rd_5e_data", SEL_RD, 8'h5E);
        expect_val("rd_5e_master_sda", SEL_MCAP, 9'h000);
        expect_val("rd_5e_line", SEL_CAP, 9'h0BD);
        expect_val("rd_5e_latency", SEL_LAT, 36 * CLK_DIV + 1);
        run_cmd(OP_READ, 8'h00, 1'b0, 1'b0);
        sbyte = 8'hC3;
        expect_val("rd_c3_data", SEL_RD, 8'hC3);
        expect_val("rd_c3_master_sda", SEL_MCAP, 9'h001);
        expect_val("rd_c3_line", SEL_CAP, 9'h186);
        expect_val("rd_c3_ack_kept", SEL_ACK, 1);
        run_cmd(OP_READ, 8'h00, 1'b1, 1'b0);

        // WRITE 0x3C, no slave response
        smode = 0;
        expect_val("wr_3c_ack", SEL_ACK, 0);
        expect_val("wr_3c_bits", SEL_CAP, 9'h079);
        expect_val("wr_3c_scl_held", SEL_SCL, 1);
        expect_val("wr_3c_sda_rel", SEL_SDA, 0);
        expect_val("wr_3c_rd_kept", SEL_RD, 8'hC3);
        run_cmd(OP_WRITE, 8'h3C, 1'b0, 1'b0);

        // ignored mid-command request, then reset just before tick 20 of a WRITE
        smode     = 1;
        cmd_op    = OP_WRITE;
        wr_data   = 8'h96;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        acc = cyc + 1;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        while (cyc < acc + 30) begin
            @(posedge clk); #2;
        end
        cmd_valid = 1'b1;
        cmd_op    = OP_STOP;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        check("busy_ready_low", {31'd0, cmd_ready}, 0);
        while (cyc < acc + 4 * 20 - 1) begin
            @(posedge clk); #2;
        end
        check("busy_scl_rises", rises, 5);
        rst_n = 1'b0;
        #1;
        check("abort_scl_oe", {31'd0, scl_oe}, 0);
        check("abort_sda_oe", {31'd0, sda_oe}, 0);
        check("abort_done", {31'd0, done}, 0);
        check("abort_cmd_ready", {31'd0, cmd_ready}, 1);
        check("abort_rd_data", {24'd0, rd_data}, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        smode = 0;
        #1;
        check("release_cmd_ready", {31'd0, cmd_ready}, 1);
        n = 0;
        repeat (200) begin
            @(posedge clk); #2;
            if (done) n++;
        end
        check("no_done_after_abort", n, 0);
        check("idle_scl_oe", {31'd0, scl_oe}, 0);

        // back-to-back START, WRITE, STOP with cmd_valid held high
        expect_val("b2b_start_latency", SEL_LAT, 4 * CLK_DIV + 1);
        run_cmd(OP_START, 8'h00, 1'b0, 1'b1);
        expect_val("b2b_write_gap", SEL_GAP, 2);
        expect_val("b2b_write_latency", SEL_LAT, 36 * CLK_DIV + 1);
        run_cmd(OP_WRITE, 8'h55, 1'b0, 1'b1);
        expect_val("b2b_stop_gap", SEL_GAP, 2);
        expect_val("b2b_stop_latency", SEL_LAT, 4 * CLK_DIV + 1);
        expect_val("b2b_stop_scl_rel", SEL_SCL, 0);
        expect_val("b2b_stop_sda_rel", SEL_SDA, 0);
        run_cmd(OP_STOP, 8'h00, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8: clk cycles per SCL quarter-period tick; legal range >= 2.
REQ-002 SHALL have port clk  in  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  in  1  command request.
REQ-005 SHALL have port cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready.
REQ-006 SHALL have port cmd_op  in  2  0=START, 1=WRITE, 2=READ, 3=STOP.
REQ-007 SHALL have port wr_data  in  8  byte for WRITE, MSB first.
REQ-008 SHALL have port rd_ack  in  1  READ only: 1 = master drives ACK on the 9th bit, 0 = NACK.
REQ-009 SHALL have port rd_data  out  8  byte received by last READ.
REQ-010 SHALL have port ack_rx  out  1  slave ACK from last WRITE (1 = SDA sampled low).
REQ-011 SHALL have port done  out  1  one-cycle pulse at command completion.
REQ-012 SHALL have port scl_oe / sda_oe  out  1 each  1 = pull line low, 0 = release.
REQ-013 SHALL have port sda_i  in  1  sampled SDA line; synchronised externally.

Function
REQ-014 SHALL latch cmd_op, wr_data and rd_ack on accept; later input changes have no effect until the next accept.
REQ-015 SHALL clear the tick counter on accept; first tick fires CLK_DIV cycles after accept, then every CLK_DIV cycles.
REQ-016 SHALL implement states IDLE, START, BIT, STOP, DONE; IDLE->{START|BIT|STOP} on accept by op; START/BIT/STOP->DONE after last tick; DONE->IDLE after 1 cycle.
REQ-017 START SHALL take 4 ticks: SDA released, SCL released; SDA low at tick 2 while SCL high; SCL low at tick 4.
REQ-018 BIT SHALL run 9 bits x 4 ticks: phases 0-1 SCL low (SDA updated on entry to phase 0), phases 2-3 SCL released.
REQ-019 WRITE SHALL drive wr_data[7-i] on bit i (0 -> sda_oe=1), release SDA on bit 8, set ack_rx = ~sda_i sampled at the end of phase 2 of bit 8.
REQ-020 READ SHALL release SDA on bits 0-7, shift sda_i into rd_data at the end of phase 2 (MSB first), drive sda_oe=rd_ack on bit 8.
REQ-021 STOP SHALL take 4 ticks: SDA low, SCL released at tick 2, SDA released at tick 4.
REQ-022 Between commands after START, WRITE or READ, SCL SHALL be held low and SDA released; after STOP, both SHALL be released.
REQ-023 Command latency SHALL be: START/STOP = 4*CLK_DIV+1 cycles, WRITE/READ = 36*CLK_DIV+1 cycles, accept to done.
REQ-024 The block SHALL NOT check bus protocol order: WRITE/READ without prior START executes as specified.
REQ-025 cmd_valid while busy SHALL be ignored; a held cmd_valid is accepted in the first IDLE cycle after DONE.
REQ-026 rd_data and ack_rx SHALL update only at the sampling point and hold until the next sample.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, tick counter=0, scl_oe=0, sda_oe=0, done=0, rd_data=0, ack_rx=0, bus-held flag=0.
REQ-028 After reset release, cmd_ready SHALL be 1 in the first cycle; reset mid-command SHALL abort with both lines released and no done pulse.

Structure
REQ-029 The shared package i2c_pkg SHALL hold the cmd_op encodings, the state enumeration and the phase/bit count constants (4, 9).
REQ-030 Sub-module i2c_tick_gen SHALL produce a one-cycle tick every CLK_DIV cycles with a synchronous clear input; everything else SHALL stay in a single FSM.

Verification (CLK_DIV=4, slave model open-drain)
REQ-031 START, then STOP -> SDA falls while SCL high 8 cycles after accept; done pulses 17 cycles after each accept; both lines released at end.
REQ-032 WRITE 0xA5, slave ACKs -> 8 SCL pulses carry 1,0,1,0,0,1,0,1; ack_rx=1; done 145 cycles after accept.
REQ-033 WRITE 0x3C, slave does not drive -> ack_rx=0; SCL held low afterwards.
REQ-034 READ with slave sending 0x5E and rd_ack=0 -> rd_data=0x5E; SDA released on bit 8; then READ rd_ack=1 -> sda_oe=1 during bit 8.
REQ-035 cmd_valid pulsed mid-WRITE and rst_n asserted at tick 20 of a WRITE -> pulse ignored; after reset scl_oe=sda_oe=0, no done, cmd_ready=1.
REQ-036 Back-to-back cmd_valid held high (START, WRITE, STOP) -> each accepted exactly 1 cycle after the previous done.
